// File: rtl/gpr_wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | gpr_wb_arbiter: round-robin write-back arbiter for the 32 x 64 GPR file, |
// | with optional busy-bit scoreboard (macro GPR_WB_SCOREBOARD_EN).          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef FCU_DDATA_WIDTH
`define FCU_DDATA_WIDTH 64
`endif

module gpr_wb_arbiter #(
  parameter int DATA_WIDTH = `FCU_DDATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              wb_valid,
  input  logic [14:0]             wb_addr,
  input  logic [3*DATA_WIDTH-1:0] wb_data,
  output logic [2:0]              wb_ready,
  output logic                    gpr_wen,
  output logic [4:0]              gpr_waddr,
  output logic [DATA_WIDTH-1:0]   gpr_wdata,
  input  logic                    iss_valid,
  input  logic [4:0]              iss_rd,
  input  logic [4:0]              iss_rs1,
  input  logic [4:0]              iss_rs2,
  output logic                    iss_stall,
  output logic [31:0]             busy
);

  localparam logic [1:0] c_ptr0 = 2'd0;
  localparam logic [1:0] c_ptr1 = 2'd1;
  localparam logic [1:0] c_ptr2 = 2'd2;

  logic [1:0]            r_rr_ptr;
  logic [1:0]            w_rr_ptr_nxt;
  logic [2:0]            w_grant;
  logic                  w_xfer;
  logic [4:0]            w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic                  r_wen;
  logic [4:0]            r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rr_ptr <= c_ptr0;
    else     r_rr_ptr <= w_rr_ptr_nxt;
  end

  always_comb begin
    w_rr_ptr_nxt = r_rr_ptr;
    case (w_grant)
      3'b001:  w_rr_ptr_nxt = c_ptr1;
      3'b010:  w_rr_ptr_nxt = c_ptr2;
      3'b100:  w_rr_ptr_nxt = c_ptr0;
      default: w_rr_ptr_nxt = r_rr_ptr;
    endcase
  end

  // Grant is suppressed while rst is high so requests are ignored in reset.
  always_comb begin
    w_grant = 3'b000;
    case (r_rr_ptr)
      c_ptr1: begin
        if      (wb_valid[1]) w_grant = 3'b010;
        else if (wb_valid[2]) w_grant = 3'b100;
        else if (wb_valid[0]) w_grant = 3'b001;
      end
      c_ptr2: begin
        if      (wb_valid[2]) w_grant = 3'b100;
        else if (wb_valid[0]) w_grant = 3'b001;
        else if (wb_valid[1]) w_grant = 3'b010;
      end
      default: begin
        if      (wb_valid[0]) w_grant = 3'b001;
        else if (wb_valid[1]) w_grant = 3'b010;
        else if (wb_valid[2]) w_grant = 3'b100;
      end
    endcase
    if (rst) w_grant = 3'b000;
  end

  assign wb_ready = w_grant;
  assign w_xfer   = |w_grant;

  always_comb begin
    w_win_addr = 5'd0;
    w_win_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (w_grant[i]) begin
        w_win_addr = wb_addr[5*i +: 5];
        w_win_data = wb_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_xfer && (w_win_addr != 5'd0);
      if (w_xfer) begin
        r_waddr <= w_win_addr;
        r_wdata <= w_win_data;
      end
    end
  end

  assign gpr_wen   = r_wen;
  assign gpr_waddr = r_waddr;
  assign gpr_wdata = r_wdata;

`ifdef GPR_WB_SCOREBOARD_EN
  logic [31:0] r_busy;
  logic [31:0] w_set;
  logic [31:0] w_clr;
  logic        w_stall;

  assign w_stall = iss_valid & (r_busy[iss_rs1] | r_busy[iss_rs2] | r_busy[iss_rd]);

  // Clear follows the registered write so busy drops as the file commits it.
  always_comb begin
    w_set = 32'd0;
    w_clr = 32'd0;
    if (iss_valid && !w_stall && (iss_rd != 5'd0)) w_set[iss_rd] = 1'b1;
    if (r_wen) w_clr[r_waddr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= 32'd0;
    else     r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
  end

  assign busy      = r_busy;
  assign iss_stall = w_stall;
`else
  logic w_unused_iss;
  assign w_unused_iss = ^{iss_valid, iss_rd, iss_rs1, iss_rs2};
  assign busy         = 32'd0;
  assign iss_stall    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_gpr_wb_arbiter: self-checking bench for gpr_wb_arbiter.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_gpr_wb_arbiter;

  localparam int DW = 64;
`ifdef GPR_WB_SCOREBOARD_EN
  localparam bit c_sb = 1'b1;
`else
  localparam bit c_sb = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    wb_valid = '0;
  logic [14:0]   wb_addr = '0;
  logic [3*DW-1:0] wb_data = '0;
  logic [2:0]    wb_ready;
  logic          gpr_wen;
  logic [4:0]    gpr_waddr;
  logic [DW-1:0] gpr_wdata;
  logic          iss_valid = 1'b0;
  logic [4:0]    iss_rd = '0;
  logic [4:0]    iss_rs1 = '0;
  logic [4:0]    iss_rs2 = '0;
  logic          iss_stall;
  logic [31:0]   busy;

  gpr_wb_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_stall(iss_stall), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wen;
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int checks = 0;
  int errors = 0;

  int            m_ptr;
  logic          m_wen;
  logic [4:0]    m_waddr;
  logic [DW-1:0] m_wdata;
  logic [31:0]   m_busy;

  function automatic logic [2:0] model_grant(input logic [2:0] v, input int p);
    int j;
    for (int k = 0; k < 3; k++) begin
      j = (p + k) % 3;
      if (v[j]) return 3'b001 << j;
    end
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_busy = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [DW-1:0] d);
    wb_valid[i] = v;
    wb_addr[i*5 +: 5] = a;
    wb_data[i*DW +: DW] = d;
  endtask

  task automatic set_iss(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    iss_valid = v; iss_rd = rd; iss_rs1 = rs1; iss_rs2 = rs2;
  endtask

  // One clock: check combinational outputs mid-cycle, queue the expected write, check it after the edge.
  task automatic cycle(input string tag);
    wr_t e;
    logic [2:0] g;
    logic stall_e;
    logic [31:0] set_m, clr_m;
    int idx;
    @(negedge clk);
    g = model_grant(wb_valid, m_ptr);
    checks++;
    if (wb_ready !== g) begin
      errors++; $display("FAIL %s grant: got %b expected %b", tag, wb_ready, g);
    end
    stall_e = c_sb && iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]);
    checks++;
    if (iss_stall !== stall_e) begin
      errors++; $display("FAIL %s iss_stall: got %b expected %b", tag, iss_stall, stall_e);
    end
    checks++;
    if (busy !== m_busy) begin
      errors++; $display("FAIL %s busy: got %h expected %h", tag, busy, m_busy);
    end
    if (g != 3'b000) begin
      idx = 0;
      for (int j = 0; j < 3; j++) if (g[j]) idx = j;
      e.addr = wb_addr[idx*5 +: 5];
      e.data = wb_data[idx*DW +: DW];
      e.wen  = (e.addr != 5'd0);
      m_ptr  = (idx + 1) % 3;
    end else begin
      e.wen = 1'b0; e.addr = m_waddr; e.data = m_wdata;
    end
    exp_q.push_back(e);
    set_m = '0;
    if (c_sb && iss_valid && !stall_e && iss_rd != 5'd0) set_m[iss_rd] = 1'b1;
    clr_m = '0;
    if (c_sb && m_wen) clr_m[m_waddr] = 1'b1;
    @(posedge clk); #1;
    m_busy = ((m_busy & ~clr_m) | set_m) & ~32'h1;
    e = exp_q.pop_front();
    checks++;
    if ({gpr_wen, gpr_waddr, gpr_wdata} !== e) begin
      errors++;
      $display("FAIL %s write: got wen=%b addr=%0d data=%h expected wen=%b addr=%0d data=%h",
               tag, gpr_wen, gpr_waddr, gpr_wdata, e.wen, e.addr, e.data);
    end
    m_wen = e.wen; m_waddr = e.addr; m_wdata = e.data;
  endtask

  task automatic test_reset();
    set_req(0, 1'b1, 5'd5, 64'h5555);
    set_req(1, 1'b1, 5'd6, 64'h6666);
    set_req(2, 1'b1, 5'd7, 64'h7777);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (wb_ready !== 3'b000 || gpr_wen !== 1'b0 || busy !== 32'd0 || iss_stall !== 1'b0 ||
          gpr_waddr !== 5'd0 || gpr_wdata !== '0) begin
        errors++;
        $display("FAIL reset_state: got ready=%b wen=%b busy=%h stall=%b addr=%0d data=%h expected all zero",
                 wb_ready, gpr_wen, busy, iss_stall, gpr_waddr, gpr_wdata);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cycle("first_grant");
  endtask

  task automatic test_contention();
    repeat (6) cycle("contention");
  endtask

  task automatic test_single();
    set_req(0, 1'b0, 5'd0, '0);
    set_req(2, 1'b0, 5'd0, '0);
    set_req(1, 1'b1, 5'd9, 64'hDEAD_BEEF);
    cycle("single");
    set_req(1, 1'b0, 5'd0, '0);
    cycle("single_idle");
  endtask

  task automatic test_addr_zero();
    set_iss(1'b1, 5'd7, 5'd0, 5'd0);
    cycle("reserve_r7");
    set_iss(1'b0, 5'd0, 5'd0, 5'd0);
    set_req(2, 1'b1, 5'd0, 64'h1234_5678);
    cycle("addr0");
    set_req(2, 1'b0, 5'd0, '0);
    cycle("addr0_idle");
  endtask

  task automatic test_scoreboard();
    set_iss(1'b1, 5'd3, 5'd0, 5'd0);
    cycle("sb_reserve");
    set_iss(1'b1, 5'd0, 5'd3, 5'd0);
    cycle("sb_stall");
    set_req(0, 1'b1, 5'd3, 64'hA5A5_0003);
    cycle("sb_wb_grant");
    set_req(0, 1'b0, 5'd0, '0);
    cycle("sb_wen_cycle");
    cycle("sb_released");
    set_iss(1'b0, 5'd0, 5'd0, 5'd0);
    cycle("sb_idle");
  endtask

  task automatic test_reset_mid();
    set_iss(1'b1, 5'd3, 5'd0, 5'd0);
    set_req(0, 1'b1, 5'd5, 64'hCAFE);
    cycle("mid_setup");
    set_iss(1'b0, 5'd0, 5'd0, 5'd0);
    set_req(0, 1'b0, 5'd0, '0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (gpr_wen !== 1'b0 || busy !== 32'd0 || gpr_waddr !== 5'd0 || gpr_wdata !== '0 || iss_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got wen=%b busy=%h addr=%0d data=%h stall=%b expected all zero",
               gpr_wen, busy, gpr_waddr, gpr_wdata, iss_stall);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    set_req(2, 1'b1, 5'd12, 64'hBEEF_0012);
    cycle("after_reset");
    set_req(2, 1'b0, 5'd0, '0);
    cycle("after_reset_idle");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_contention();
    test_single();
    test_addr_zero();
    test_scoreboard();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
